timer_input_sequencer: RTL and testbench
========================================

Name: timer_input_sequencer

Overview:
Sequencing controller for the microwave timer-input datapath. Shifts keypad BCD digits into a 4-digit MM:SS register, drives the 2:1 load-path select between the keypad shift path and the countdown path, and counts the entered time down once per second while the magnetron is enabled. It sits between the keypad decoder and the display/magnetron driver in microwave_controller/timer_input_control.

Parameters:
TICK_DIV, 100, clock cycles per one-second countdown tick (≥2; benches use 4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  keypad code; 0-9 = digit, 10-15 ignored
start  in  1  level-sampled start request
stop_clear  in  1  level-sampled stop/clear request
door_closed  in  1  1 = door closed (interlock)
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens
sec_ones  out  4  BCD seconds ones
load_sel  out  1  mux select: 0 = keypad shift path, 1 = countdown path
mag_on  out  1  magnetron enable
done  out  1  high while in DONE
state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (async, rst_n=0): all digits 0, state IDLE, prescaler 0, mag_on=0, load_sel=0, done=0. Applies immediately, including mid-RUN.
- All outputs registered; mag_on=load_sel=(state==RUN), done=(state==DONE), updated on the same edge as state.
- "Time zero" means all four digits == 0.
- Priority each cycle: stop_clear > start > key_valid.
- IDLE:
  - key_valid with code 0-9: shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code. Codes 10-15: no change.
  - start & door_closed & time nonzero: -> RUN, prescaler<=0; a key strobed in the same cycle is dropped.
  - start with door open or time zero: stay IDLE, no change.
  - stop_clear: all digits <= 0.
- RUN:
  - key_valid ignored.
  - Prescaler counts 0..TICK_DIV-1; a tick occurs at TICK_DIV-1, then prescaler wraps to 0. First tick TICK_DIV cycles after entering RUN.
  - On a tick, decrement MM:SS in BCD with borrow: sec_ones 0->9 borrow; sec_tens 0->5 borrow; min_ones 0->9 borrow; min_tens decrements. A digit that is nonzero decrements by 1 with no borrow, so entered seconds >59 (e.g. 09:90) count down literally.
  - Tick at value 00:01: digits become 00:00 and state -> DONE on the same edge.
  - door_closed=0 or stop_clear: -> PAUSE; prescaler and digits held. Door-open takes effect even on a tick cycle; no decrement on that edge.
- PAUSE: mag_on=0.
  - stop_clear: -> IDLE, digits cleared, prescaler 0.
  - start & door_closed: -> RUN, prescaler resumes from held value. No partial-second loss.
  - start with door open: stay PAUSE.
- DONE: digits 00:00.
  - stop_clear, key_valid (any code, not shifted), or door_closed falling to 0: -> IDLE.
  - start ignored.
- Illegal state encodings cannot occur; the default branch returns to IDLE with digits cleared.

Test Plan:
1. Reset with rst_n=0 mid-RUN at 01:23 -> outputs immediately 00:00, state=00, mag_on=0, load_sel=0, done=0, without a clock edge.
2. IDLE, keys 1,3,0 then key 11 -> display 01:30 after the third key; the 11 strobe leaves 01:30 unchanged; stop_clear -> 00:00.
3. TICK_DIV=4, enter 00:10, start, door closed -> state=01, mag_on=1, load_sel=1 one edge later; 00:09 four cycles later; after 40 cycles 00:00 with state=11, done=1, mag_on=0 on that edge.
4. Run from 01:00, one tick -> 00:59; from 10:00 one tick -> 09:59.
5. Running at 00:05 with prescaler=2, drop door_closed -> PAUSE, digits and prescaler frozen for 20 cycles; restore door + start -> RUN, next tick after 2 cycles gives 00:04.
6. IDLE at 00:00, start -> stays IDLE. At 00:30, start and stop_clear together -> stays IDLE, digits cleared. In DONE, key_valid -> IDLE and digits remain 00:00.

Source files
------------

// File: rtl/timer_input_sequencer_if.sv
// Keypad/control inputs and display/driver outputs of the microwave timer-input sequencer.
interface timer_input_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       load_sel;
    logic       mag_on;
    logic       done;
    logic [1:0] state;

    modport master (
        output key_valid, key_code, start, stop_clear, door_closed,
        input  min_tens, min_ones, sec_tens, sec_ones, load_sel, mag_on, done, state
    );
    modport slave (
        input  key_valid, key_code, start, stop_clear, door_closed,
        output min_tens, min_ones, sec_tens, sec_ones, load_sel, mag_on, done, state
    );
endinterface

// File: rtl/timer_input_sequencer.sv
// Keypad MM:SS entry, run/pause/done sequencing and once-per-second BCD countdown.
module timer_input_sequencer #(
    parameter int TICK_DIV = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    timer_input_sequencer_if.slave tis
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_e;

    state_e        state_q, state_d;
    logic [15:0]   dig_q, dig_d;    // {min_tens, min_ones, sec_tens, sec_ones}
    logic [PW-1:0] pre_q, pre_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;
    logic          time_zero, tick;

    // Digit-wise borrow; seconds tens wraps to 5 but entered values >59 count down as-is.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign time_zero = (dig_q == 16'h0000);
    assign tick      = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        pre_d   = pre_q;
        unique case (state_q)
            IDLE: begin
                if (tis.stop_clear) dig_d = 16'h0000;
                else if (tis.start) begin
                    if (tis.door_closed && !time_zero) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end else if (tis.key_valid && tis.key_code <= 4'd9)
                    dig_d = {dig_q[11:0], tis.key_code};
            end
            RUN: begin
                if (tis.stop_clear || !tis.door_closed) state_d = PAUSE;
                else if (tick) begin
                    pre_d = '0;
                    dig_d = bcd_dec(dig_q);
                    if (dig_q == 16'h0001) state_d = DONE;
                end else pre_d = pre_q + PW'(1);
            end
            PAUSE: begin
                if (tis.stop_clear) begin
                    state_d = IDLE;
                    dig_d   = 16'h0000;
                    pre_d   = '0;
                end else if (tis.start && tis.door_closed) state_d = RUN;
            end
            DONE: begin
                if (tis.stop_clear || tis.key_valid || !tis.door_closed) begin
                    state_d = IDLE;
                    pre_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                dig_d   = 16'h0000;
                pre_d   = '0;
            end
        endcase
        mag_on_d = (state_d == RUN);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dig_q    <= 16'h0000;
            pre_q    <= '0;
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            pre_q    <= pre_d;
            mag_on_q <= mag_on_d;
            done_q   <= done_d;
        end
    end

    assign tis.min_tens = dig_q[15:12];
    assign tis.min_ones = dig_q[11:8];
    assign tis.sec_tens = dig_q[7:4];
    assign tis.sec_ones = dig_q[3:0];
    assign tis.load_sel = mag_on_q;
    assign tis.mag_on   = mag_on_q;
    assign tis.done     = done_q;
    assign tis.state    = state_q;
endmodule

// File: tb/tb_timer_input_sequencer.sv
// Table vectors, hand-written corner sequences and a random run against a time-value model.
module tb_timer_input_sequencer;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    timer_input_sequencer_if bus ();
    timer_input_sequencer #(.TICK_DIV(TD)) dut (.clk(clk), .rst_n(rst_n), .tis(bus));

    // Reference: time as minutes/seconds integers, state as spec numbering.
    int m_min, m_sec, m_st, m_pre;

    function automatic logic [15:0] m_dig();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_step();
        int n;
        n = m_min * 100 + m_sec;
        case (m_st)
            0: begin
                if (bus.stop_clear) begin m_min = 0; m_sec = 0; end
                else if (bus.start) begin
                    if (bus.door_closed && n != 0) begin m_st = 1; m_pre = 0; end
                end else if (bus.key_valid && bus.key_code < 10) begin
                    n = (n * 10 + int'(bus.key_code)) % 10000;
                    m_min = n / 100; m_sec = n % 100;
                end
            end
            1: begin
                if (bus.stop_clear || !bus.door_closed) m_st = 2;
                else if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_sec = 59; m_min--; end
                    if (m_min == 0 && m_sec == 0) m_st = 3;
                end else m_pre++;
            end
            2: begin
                if (bus.stop_clear) begin m_st = 0; m_min = 0; m_sec = 0; m_pre = 0; end
                else if (bus.start && bus.door_closed) m_st = 1;
            end
            default: if (bus.stop_clear || bus.key_valid || !bus.door_closed) m_st = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] dig();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    function automatic logic [4:0] stat();
        return {bus.state, bus.mag_on, bus.load_sel, bus.done};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.key_valid = 0; bus.key_code = 0; bus.start = 0; bus.stop_clear = 0; bus.door_closed = 1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        m_min = 0; m_sec = 0; m_st = 0; m_pre = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int c);
        bus.key_valid = 1; bus.key_code = 4'(c);
        step();
        bus.key_valid = 0;
    endtask

    task automatic go();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    typedef struct {
        logic kv; logic [3:0] code; logic st; logic sc; logic door;
        logic [15:0] exp_dig; logic [1:0] exp_state;
    } vec_t;
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 16'h0001, 2'd0};
        tbl[1]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 16'h0013, 2'd0};
        tbl[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 16'h0130, 2'd0};
        tbl[3]  = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 16'h0130, 2'd0};
        tbl[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 2'd0};
        tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 16'h0000, 2'd0};
        tbl[6]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 16'h0003, 2'd0};
        tbl[7]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 16'h0030, 2'd0};
        tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 16'h0000, 2'd0};
        tbl[9]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 16'h0005, 2'd0};
        tbl[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 16'h0005, 2'd0};
        tbl[11] = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 16'h0005, 2'd1};
        tbl[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0005, 2'd2};
        tbl[13] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 2'd0};

        do_reset();
        chk("reset_dig", 32'(dig()), 32'h0);
        chk("reset_stat", 32'(stat()), 32'h0);

        for (int i = 0; i < 14; i++) begin
            bus.key_valid = tbl[i].kv; bus.key_code = tbl[i].code; bus.start = tbl[i].st;
            bus.stop_clear = tbl[i].sc; bus.door_closed = tbl[i].door;
            step();
            chk($sformatf("vec%0d_dig", i), 32'(dig()), 32'(tbl[i].exp_dig));
            chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].exp_state));
        end

        // Asynchronous reset mid-RUN at 01:23.
        do_reset();
        key(1); key(2); key(3); go(); step();
        chk("pre_rst_dig", 32'(dig()), 32'h0123);
        rst_n = 0;
        #1;
        chk("async_rst_dig", 32'(dig()), 32'h0);
        chk("async_rst_stat", 32'(stat()), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // 00:10 countdown to DONE, then a key returns to IDLE.
        do_reset();
        key(1); key(0); go();
        chk("run_entry_stat", 32'(stat()), 32'b01110);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 3) chk("pre_first_tick", 32'(dig()), 32'h0010);
            if (i == 4) chk("first_tick", 32'(dig()), 32'h0009);
            if (i == 39) chk("last_run_stat", 32'(stat()), 32'b01110);
        end
        chk("done_dig", 32'(dig()), 32'h0);
        chk("done_stat", 32'(stat()), 32'b11001);
        go();
        chk("done_start_ignored", 32'(bus.state), 32'd3);
        key(5);
        chk("done_key_dig", 32'(dig()), 32'h0);
        chk("done_key_stat", 32'(stat()), 32'b00000);

        // Minute borrow cases.
        do_reset();
        key(1); key(0); key(0); go();
        repeat (4) step();
        chk("borrow_0100", 32'(dig()), 32'h0059);
        do_reset();
        key(1); key(0); key(0); key(0); go();
        repeat (4) step();
        chk("borrow_1000", 32'(dig()), 32'h0959);

        // Pause with prescaler at 2, resume without partial-second loss.
        do_reset();
        key(5); go();
        step(); step();
        bus.door_closed = 0;
        step();
        chk("pause_stat", 32'(stat()), 32'b10000);
        for (int i = 0; i < 20; i++) step();
        chk("pause_held", 32'(dig()), 32'h0005);
        bus.door_closed = 1;
        go();
        chk("resume_stat", 32'(stat()), 32'b01110);
        step();
        chk("resume_no_tick", 32'(dig()), 32'h0005);
        step();
        chk("resume_tick", 32'(dig()), 32'h0004);

        // DONE exits to IDLE when the door opens.
        do_reset();
        key(1); go();
        repeat (4) step();
        chk("done2_state", 32'(bus.state), 32'd3);
        bus.door_closed = 0;
        step();
        chk("done_door_exit", 32'(bus.state), 32'd0);

        // Random stimulus against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.key_valid   = ($urandom_range(0, 2) == 0);
            bus.key_code    = 4'($urandom_range(0, 15));
            bus.start       = ($urandom_range(0, 5) == 0);
            bus.stop_clear  = ($urandom_range(0, 39) == 0);
            bus.door_closed = ($urandom_range(0, 9) != 0);
            step();
            chk("rnd_dig", 32'(dig()), 32'(m_dig()));
            chk("rnd_stat", 32'(stat()),
                32'({2'(m_st), m_st == 1, m_st == 1, m_st == 3}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
